// File: rtl/avg_chan_sched.sv
// Round-robin scheduler sharing one serial 8-tap moving-average adder among NCH channels.
// Each channel owns a DEPTH-entry window; a granted sample is shifted in, then summed one tap per cycle.
module avg_chan_sched #(
  parameter int NCH   = 4,
  parameter int CW    = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ACCW  = 11
) (
  input  logic                 clk,
  input  logic                 rs,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [CW-1:0]        out_chan,
  output logic [WIDTH-1:0]     out_avg,
  output logic                 busy
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    rr_ptr_reg;
  logic [CW-1:0]    cur_reg;
  logic [IW-1:0]    idx_reg;
  logic [ACCW-1:0]  acc_reg;
  logic             out_valid_reg;
  logic [CW-1:0]    out_chan_reg;
  logic [WIDTH-1:0] out_avg_reg;

  logic [WIDTH-1:0] win_reg [NCH][DEPTH];
  logic [WIDTH-1:0] sample  [NCH];

  logic [CW-1:0]    grant;
  logic [CW-1:0]    cand;
  logic             found;
  logic             hs;
  logic [WIDTH-1:0] tap;

  genvar gi, gj;

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign sample[gi]   = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = hs && (grant == CW'(gi));
    end
  endgenerate

  // Scan offsets from the far end so the channel nearest rr_ptr is the last writer and wins.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = rr_ptr_reg + CW'(i);
      if (in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign hs   = (state_reg == IDLE) && found;
  assign tap  = win_reg[cur_reg][idx_reg];
  assign busy = (state_reg != IDLE);

  // Newest sample lives at index DEPTH-1; the oldest falls off index 0.
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_win
      for (gj = 0; gj < DEPTH; gj++) begin : g_tap
        always_ff @(posedge clk) begin
          if (!rs) begin
            win_reg[gi][gj] <= '0;
          end else if (hs && (grant == CW'(gi))) begin
            if (gj == DEPTH - 1) begin
              win_reg[gi][gj] <= sample[gi];
            end else begin
              win_reg[gi][gj] <= win_reg[gi][(gj + 1) % DEPTH];
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rs) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      cur_reg       <= '0;
      idx_reg       <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_chan_reg  <= '0;
      out_avg_reg   <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hs) begin
            acc_reg    <= '0;
            idx_reg    <= '0;
            cur_reg    <= grant;
            rr_ptr_reg <= grant + CW'(1);
            state_reg  <= ACC;
          end
        end
        ACC: begin
          acc_reg <= acc_reg + {{(ACCW-WIDTH){1'b0}}, tap};
          idx_reg <= idx_reg + IW'(1);
          if (idx_reg == IW'(DEPTH - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          out_avg_reg   <= acc_reg[IW +: WIDTH];
          out_chan_reg  <= cur_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_chan  = out_chan_reg;
  assign out_avg   = out_avg_reg;

endmodule

// File: tb/tb_avg_chan_sched.sv
// Bench for avg_chan_sched: window/rotation model checked every cycle, plus directed literal results.
module tb_avg_chan_sched;

  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int ACCW  = 11;

  logic                 clk = 1'b0;
  logic                 rs = 1'b0;
  logic [NCH-1:0]       in_valid = '0;
  logic [NCH*WIDTH-1:0] in_data = '0;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [CW-1:0]        out_chan;
  logic [WIDTH-1:0]     out_avg;
  logic                 busy;

  avg_chan_sched #(.NCH(NCH), .CW(CW), .WIDTH(WIDTH), .DEPTH(DEPTH), .ACCW(ACCW)) dut (
    .clk(clk), .rs(rs), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_chan(out_chan), .out_avg(out_avg), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: per-channel sample history, rotation pointer, edges elapsed since the last handshake.
  int  m_win [NCH][DEPTH];
  int  m_rr = 0;
  int  m_phase = -1;
  int  m_pend_avg = 0;
  int  m_pend_chan = 0;
  int  m_avg = 0;
  int  m_chan = 0;
  bit  m_ov = 1'b0;
  bit  m_live = 1'b0;
  int  res_chan[$];
  int  res_avg[$];
  int  grants[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int exp_g;
    int c;
    int sum;
    logic [NCH-1:0] exp_ready;
    exp_g = -1;
    c = 0;
    sum = 0;
    exp_ready = '0;
    if (m_live && m_phase < 0) begin
      for (int i = 0; i < NCH; i++) begin
        c = (m_rr + i) % NCH;
        if (exp_g < 0 && in_valid[c]) exp_g = c;
      end
    end
    if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
    if (m_live) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("out_avg", {24'd0, out_avg}, m_avg);
      chk("out_chan", {30'd0, out_chan}, m_chan);
      chk("busy", {31'd0, busy}, (m_phase >= 0) ? 1 : 0);
      chk("in_ready", {28'd0, in_ready}, {28'd0, exp_ready});
      chk("in_ready_onehot0", {31'd0, $onehot0(in_ready)}, 1);
    end
    if (out_valid === 1'b1) begin
      res_chan.push_back(int'(out_chan));
      res_avg.push_back(int'(out_avg));
      $display("result: chan %0d avg %0d (expected chan %0d avg %0d)", out_chan, out_avg, m_chan, m_avg);
    end
    // Advance the model over the coming posedge.
    if (!rs) begin
      for (int k = 0; k < NCH; k++)
        for (int j = 0; j < DEPTH; j++) m_win[k][j] = 0;
      m_rr = 0;
      m_phase = -1;
      m_ov = 1'b0;
      m_avg = 0;
      m_chan = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_ov = 1'b0;
      if (m_phase >= 0) begin
        m_phase++;
        if (m_phase == 9) begin
          m_ov = 1'b1;
          m_avg = m_pend_avg;
          m_chan = m_pend_chan;
          m_phase = -1;
        end
      end else if (exp_g >= 0) begin
        for (int j = 0; j < DEPTH - 1; j++) m_win[exp_g][j] = m_win[exp_g][j+1];
        m_win[exp_g][DEPTH-1] = int'(in_data[exp_g*WIDTH +: WIDTH]);
        for (int j = 0; j < DEPTH; j++) sum += m_win[exp_g][j];
        m_pend_avg = sum / 8;
        m_pend_chan = exp_g;
        m_rr = (exp_g + 1) % NCH;
        m_phase = 0;
        grants.push_back(exp_g);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rs = 1'b0;
    in_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rs = 1'b1;
  endtask

  task automatic send(input int ch, input int data);
    int t;
    t = 0;
    in_data[ch*WIDTH +: WIDTH] = data[WIDTH-1:0];
    in_valid[ch] = 1'b1;
    @(negedge clk);
    while (in_ready[ch] !== 1'b1 && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout ch%0d: got no in_ready, expected a handshake", ch);
    end
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int t;
    t = 0;
    while (res_avg.size() < n && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (res_avg.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: got %0d results, expected %0d", res_avg.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_res(input string name, input int k, input int ch, input int avg);
    if (k >= res_avg.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no result #%0d, expected chan %0d avg %0d", name, k, ch, avg);
    end else begin
      chk($sformatf("%s_chan", name), res_chan[k], ch);
      chk($sformatf("%s_avg", name), res_avg[k], avg);
    end
  endtask

  initial begin
    int base;
    int gbase;
    int exp_chan2 [10];
    int t2_avg [8];
    exp_chan2 = '{31, 63, 95, 127, 159, 191, 223, 255, 255, 223};
    t2_avg = '{1, 2, 3, 4, 2, 4, 6, 8};

    // T1: ch0 sends 80 eight times back to back.
    do_reset();
    @(negedge clk);
    chk("reset_out_avg", {24'd0, out_avg}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_in_ready", {28'd0, in_ready}, 0);
    base = res_avg.size();
    for (int k = 0; k < 8; k++) send(0, 80);
    wait_results(base + 8);
    for (int k = 0; k < 8; k++) expect_res($sformatf("t1_%0d", k), base + k, 0, 10 * (k + 1));

    // T2: every channel requests continuously.
    do_reset();
    base = res_avg.size();
    gbase = grants.size();
    for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = 8'(8 * (k + 1));
    in_valid = '1;
    wait_results(base + 8);
    in_valid = '0;
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      expect_res($sformatf("t2_%0d", k), base + k, k % NCH, t2_avg[k]);
      if (gbase + k < grants.size()) chk($sformatf("t2_grant_%0d", k), grants[gbase + k], k % NCH);
    end

    // T3: full-scale samples wrap the window, then a zero displaces one of them.
    do_reset();
    base = res_avg.size();
    for (int k = 0; k < 9; k++) send(2, 255);
    send(2, 0);
    wait_results(base + 10);
    for (int k = 0; k < 10; k++) expect_res($sformatf("t3_%0d", k), base + k, 2, exp_chan2[k]);

    // T4: reset lands in the 4th ACC cycle of a ch1 sequence.
    do_reset();
    base = res_avg.size();
    send(1, 40);
    repeat (3) @(posedge clk);
    #1 rs = 1'b0;
    @(posedge clk);
    #1 rs = 1'b1;
    @(negedge clk);
    chk("t4_out_avg", {24'd0, out_avg}, 0);
    chk("t4_busy", {31'd0, busy}, 0);
    repeat (14) @(posedge clk);
    #1;
    chk("t4_no_result", res_avg.size(), base);
    send(1, 16);
    wait_results(base + 1);
    expect_res("t4_after", base, 1, 2);

    // T5: truncation of a small average.
    do_reset();
    base = res_avg.size();
    send(3, 7);
    wait_results(base + 1);
    send(3, 1);
    wait_results(base + 2);
    expect_res("t5_a", base, 3, 0);
    expect_res("t5_b", base + 1, 3, 1);

    // T6: ch3 requests only while ch1 is accumulating, then withdraws.
    do_reset();
    base = res_avg.size();
    send(3, 40);
    wait_results(base + 1);
    send(1, 8);
    @(posedge clk); #1;
    in_data[3*WIDTH +: WIDTH] = 8'd200;
    in_valid[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid[3] = 1'b0;
    wait_results(base + 2);
    send(3, 16);
    wait_results(base + 3);
    expect_res("t6_a", base, 3, 5);
    expect_res("t6_b", base + 1, 1, 1);
    expect_res("t6_c", base + 2, 3, 7);
    chk("t6_result_count", res_avg.size(), base + 3);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
